// File: rtl/alu_sin_tx.sv
// alu_sin_tx: serializes one ALU operation (B, A, op + CRC4) onto the idle-high sin line,
// with optional dropped A[7:0] frame or corrupted CRC.
module alu_sin_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    input  logic        err_data_i,
    input  logic        err_crc_i,
    output logic        sin,
    output logic        done_o,
    output logic [3:0]  crc_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  bit_q, bit_d, frame_q, frame_d, gap_q, gap_d;
    logic        ready_q, ready_d, done_q, done_d;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        err_data_q;
    logic [3:0]  crc_q;
    logic        accept, last_bit, last_frame;
    logic [63:0] ops;
    logic [7:0]  payload;

    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) c = {c[2:0], 1'b0} ^ ({4{c[3] ^ v[i]}} & 4'b0011);
        return c;
    endfunction

    assign accept     = state_q == IDLE && ready_q && start_i;
    assign last_bit   = bit_q == 4'd10;
    assign last_frame = frame_q == 4'd8;
    assign ops        = {b_q, a_q};
    // frame 8 is the CTL frame; frames 0..7 walk {B, A} from the top byte down
    assign payload    = frame_q[3] ? {1'b0, op_q, crc_q} : ops[{~frame_q[2:0], 3'b000} +: 8];
    assign sin        = state_q != SEND ? 1'b1 :
                        bit_q == 4'd0  ? 1'b0 :
                        bit_q == 4'd1  ? frame_q[3] :
                        last_bit       ? 1'b1 : payload[3'(4'd9 - bit_q)];
    assign ready_o    = ready_q;
    assign done_o     = done_q;
    assign crc_o      = crc_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        gap_d   = gap_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            ready_d = ~accept;
            state_d = accept ? SEND : IDLE;
            bit_d   = accept ? 4'd0 : bit_q;
            frame_d = accept ? 4'd0 : frame_q;
        end else if (state_q == SEND) begin
            bit_d = last_bit ? 4'd0 : bit_q + 4'd1;
            if (last_bit) begin
                frame_d = last_frame ? 4'd0 : (err_data_q && frame_q == 4'd6) ? 4'd8 : frame_q + 4'd1;
                if (last_frame) begin
                    done_d  = 1'b1;
                    gap_d   = 4'd0;
                    state_d = GAP_CYCLES == 0 ? IDLE : GAP;
                    ready_d = GAP_CYCLES == 0;
                end
            end
        end else if (state_q == GAP) begin
            gap_d = gap_q + 4'd1;
            if (gap_q == 4'(GAP_CYCLES - 1)) begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= 4'd0;
            frame_q    <= 4'd0;
            gap_q      <= 4'd0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            crc_q      <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 3'd0;
            err_data_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            gap_q   <= gap_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            if (accept) begin
                a_q        <= a_i;
                b_q        <= b_i;
                op_q       <= op_i;
                err_data_q <= err_data_i;
                crc_q      <= crc4({b_i, a_i, 1'b1, op_i}) ^ {3'b000, err_crc_i};
            end
        end
    end
endmodule

// File: tb/tb_alu_sin_tx.sv
// tb_alu_sin_tx: directed checks of alu_sin_tx framing, CRC, timing, reset and back-to-back.
module tb_alu_sin_tx;
    logic        clk = 0, rst = 1, start = 0, start0 = 0, err_data = 0, err_crc = 0;
    logic [31:0] a = 0, b = 0;
    logic [2:0]  op = 0;
    logic        ready, sin, done, ready0, sin0, done0;
    logic [3:0]  crc, crc0;
    int          n_chk = 0, n_fail = 0, n_done = 0, done_before = 0, zeros = 0;
    logic [10:0] got_fr[9];
    logic [7:0]  exp_b[9];
    logic [3:0]  m_crc;

    always #5 clk = ~clk;

    alu_sin_tx #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start_i(start), .ready_o(ready), .a_i(a), .b_i(b), .op_i(op),
        .err_data_i(err_data), .err_crc_i(err_crc), .sin(sin), .done_o(done), .crc_o(crc)
    );
    alu_sin_tx #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .ready_o(ready0), .a_i(a), .b_i(b), .op_i(op),
        .err_data_i(err_data), .err_crc_i(err_crc), .sin(sin0), .done_o(done0), .crc_o(crc0)
    );

    always @(negedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frm(input logic ctl, input logic [7:0] p);
        return {1'b0, ctl, p, 1'b1};
    endfunction

    // remainder of M(x)*x^4 by long division with x^4+x+1
    function automatic logic [3:0] crc_model(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'h0};
        for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic start_pkt(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] ov,
                             input logic ed, input logic ec);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", ready, 1);
        a = av; b = bv; op = ov; err_data = ed; err_crc = ec; start = 1;
        done_before = n_done;
        @(posedge clk);
    endtask

    task automatic capture(input int nf, input bit disturb);
        int t;
        t = 0;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                got_fr[f] = {got_fr[f][9:0], sin};
                if (t == 0) start = 0;
                if (disturb && t == 20) begin start = 1; a = ~a; op = 3'b111; end
                if (disturb && t == 30) start = 0;
                t++;
            end
        end
    endtask

    task automatic check_pkt(input string tag, input int nf);
        for (int f = 0; f < nf; f++) chk($sformatf("%s_frame%0d", tag, f), got_fr[f], frm(f == nf - 1, exp_b[f]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, {done, sin, ready}, 3'b110);
        @(negedge clk);
        chk({tag, "_gap1"}, {done, sin, ready}, 3'b010);
        @(negedge clk);
        chk({tag, "_ready_back"}, {done, sin, ready}, 3'b011);
        chk({tag, "_done_count"}, n_done - done_before, 1);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {sin, ready, done, crc}, 7'b1000000);
        end
        rst = 0;
        @(negedge clk);
        chk("ready_after_reset", ready, 1);

        // add 1 + 2, inputs disturbed mid-packet; CRC hand-computed as 4'hC
        start_pkt(32'h1, 32'h2, 3'b100, 0, 0);
        capture(9, 1);
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h4C};
        chk("add_crc_o", crc, 4'hC);
        check_pkt("add", 9);

        // dropped A[7:0] frame
        start_pkt(32'hAABBCCDD, 32'h11223344, 3'b000, 1, 0);
        capture(8, 0);
        m_crc = crc_model({32'h11223344, 32'hAABBCCDD, 1'b1, 3'b000});
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, {4'h0, m_crc}, 8'h00};
        chk("errdata_crc_o", crc, m_crc);
        check_pkt("errdata", 8);

        // sub 5 - 3 with CRC corrupted: true CRC 4'hF, sent 4'hE
        start_pkt(32'h5, 32'h3, 3'b101, 0, 1);
        capture(9, 0);
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h5E};
        chk("errcrc_crc_o", crc, 4'hE);
        check_pkt("errcrc", 9);

        // reset during frame 3
        start_pkt(32'h12345678, 32'h9ABCDEF0, 3'b001, 0, 0);
        repeat (37) begin
            @(negedge clk);
            start = 0;
        end
        rst = 1;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_outputs", {sin, ready, done}, 3'b100);
        end
        rst = 0;
        @(negedge clk);
        chk("midreset_ready", ready, 1);
        zeros = 0;
        repeat (120) begin
            @(negedge clk);
            if (!sin) zeros++;
        end
        chk("midreset_sin_quiet", zeros, 0);
        chk("midreset_no_done", n_done - done_before, 0);

        // back-to-back on the zero-gap instance with start held high
        @(negedge clk);
        chk("b2b_ready0", ready0, 1);
        a = 32'h0F0F0F0F; b = 32'hF0F0F0F0; op = 3'b100; err_data = 0; err_crc = 0; start0 = 1;
        @(posedge clk);
        for (int t = 0; t <= 100; t++) begin
            @(negedge clk);
            if (t == 0) chk("b2b_first_start", {sin0, ready0}, 2'b00);
            if (t == 98) chk("b2b_last_stop", {sin0, done0}, 2'b10);
            if (t == 99) chk("b2b_done_ready", {done0, ready0, sin0}, 3'b111);
            if (t == 100) chk("b2b_second_start", {done0, ready0, sin0}, 3'b000);
        end
        start0 = 0;
        repeat (110) @(negedge clk);
        chk("b2b_idle_again", {ready0, sin0}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
